// File: rtl/usb_dev_responder.sv
// Device-side USB responder: answers OUT/IN tokens to DEV_ADDR and serves a small 64-bit word memory.
// Latency: the handshake or DATA0 request is raised the cycle after the DATA0 or IN token is seen.
// Backpressure: each tx request is held stable until tx_gotpkt; the FSM then waits for tx_sending to clear.
module usb_dev_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'd5,
  parameter int         MEM_WORDS = 16,
  parameter int         TIMEOUT   = 255,
  parameter logic [3:0] ADDR_ENDP = 4'd4,
  parameter logic [3:0] DATA_ENDP = 4'd8
) (
  input  logic                         clk,
  input  logic                         rst_L,
  input  logic                         rx_valid,
  input  logic [3:0]                   rx_pid,
  input  logic [6:0]                   rx_addr,
  input  logic [3:0]                   rx_endp,
  input  logic [63:0]                  rx_data,
  input  logic                         rx_error,
  output logic                         tx_pktready,
  output logic [3:0]                   tx_pid,
  output logic [63:0]                  tx_data,
  output logic                         tx_pkttype,
  input  logic                         tx_gotpkt,
  input  logic                         tx_sending,
  output logic [$clog2(MEM_WORDS)-1:0] mem_ptr,
  output logic                         busy
);

  localparam int PTR_W = $clog2(MEM_WORDS);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    SEND_HS   = 3'd2,
    SEND_DATA = 3'd3,
    WAIT_HS   = 3'd4,
    TX_DRAIN  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  state_t             ret_q, ret_d;
  logic [3:0]         endp_q, endp_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               drain_first_q, drain_first_d;
  logic               pktready_q, pktready_d;
  logic [3:0]         pid_q, pid_d;
  logic [63:0]        data_q, data_d;
  logic               pkttype_q, pkttype_d;
  logic               mem_we;
  logic               tok_ok;
  logic               timed_out;

  logic [63:0] mem [MEM_WORDS];

  assign tx_pktready = pktready_q;
  assign tx_pid      = pid_q;
  assign tx_data     = data_q;
  assign tx_pkttype  = pkttype_q;
  assign mem_ptr     = ptr_q;
  assign busy        = (state_q != IDLE);

  // A token we answer: clean, addressed to us, on one of our two endpoints.
  assign tok_ok = rx_valid & ~rx_error & (rx_addr == DEV_ADDR) &
                  ((rx_endp == ADDR_ENDP) | (rx_endp == DATA_ENDP));

  assign timed_out = (timer_q == TMR_W'(TIMEOUT));

  // State and output register; everything here returns to its idle value on reset.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q       <= IDLE;
      ret_q         <= IDLE;
      endp_q        <= 4'd0;
      timer_q       <= '0;
      ptr_q         <= '0;
      drain_first_q <= 1'b0;
      pktready_q    <= 1'b0;
      pid_q         <= 4'd0;
      data_q        <= 64'd0;
      pkttype_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      endp_q        <= endp_d;
      timer_q       <= timer_d;
      ptr_q         <= ptr_d;
      drain_first_q <= drain_first_d;
      pktready_q    <= pktready_d;
      pid_q         <= pid_d;
      data_q        <= data_d;
      pkttype_q     <= pkttype_d;
    end
  end

  // Word memory; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= rx_data;
    end
  end

  // Next-state logic and transmit request formation.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    endp_d        = endp_q;
    timer_d       = timer_q;
    ptr_d         = ptr_q;
    drain_first_d = drain_first_q;
    pktready_d    = pktready_q;
    pid_d         = pid_q;
    data_d        = data_q;
    pkttype_d     = pkttype_q;
    mem_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (tok_ok && rx_pid == PID_OUT) begin
          endp_d  = rx_endp;
          timer_d = '0;
          state_d = WAIT_DATA;
        end else if (tok_ok && rx_pid == PID_IN) begin
          pktready_d = 1'b1;
          if (rx_endp == DATA_ENDP) begin
            // Snapshot the word now so the payload stays fixed for the whole request.
            pkttype_d = 1'b1;
            pid_d     = PID_DATA0;
            data_d    = mem[ptr_q];
            state_d   = SEND_DATA;
          end else begin
            // The address endpoint is write-only; refuse reads of it.
            pkttype_d = 1'b0;
            pid_d     = PID_NAK;
            state_d   = SEND_HS;
          end
        end
      end

      WAIT_DATA: begin
        if (rx_valid) begin
          if (rx_pid == PID_DATA0 && !rx_error) begin
            if (endp_q == ADDR_ENDP) begin
              ptr_d = rx_data[PTR_W-1:0];
            end else begin
              mem_we = 1'b1;
              ptr_d  = ptr_q + 1'b1;
            end
            pktready_d = 1'b1;
            pkttype_d  = 1'b0;
            pid_d      = PID_ACK;
            state_d    = SEND_HS;
          end else if (rx_pid == PID_DATA0) begin
            pktready_d = 1'b1;
            pkttype_d  = 1'b0;
            pid_d      = PID_NAK;
            state_d    = SEND_HS;
          end else begin
            state_d = IDLE;
          end
        end else if (timed_out) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      SEND_HS: begin
        if (tx_gotpkt) begin
          pktready_d    = 1'b0;
          ret_d         = IDLE;
          drain_first_d = 1'b1;
          state_d       = TX_DRAIN;
        end
      end

      SEND_DATA: begin
        if (tx_gotpkt) begin
          pktready_d    = 1'b0;
          ret_d         = WAIT_HS;
          drain_first_d = 1'b1;
          state_d       = TX_DRAIN;
        end
      end

      TX_DRAIN: begin
        // The encoder may not raise tx_sending until the cycle after gotpkt,
        // so skip one cycle before trusting it.
        if (drain_first_q) begin
          drain_first_d = 1'b0;
        end else if (!tx_sending) begin
          timer_d = '0;
          state_d = ret_q;
        end
      end

      WAIT_HS: begin
        if (rx_valid) begin
          // Only a clean ACK consumes the word; anything else leaves the
          // pointer so the host's retry reads the same word again.
          if (rx_pid == PID_ACK && !rx_error) begin
            ptr_d = ptr_q + 1'b1;
          end
          state_d = IDLE;
        end else if (timed_out) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_dev_responder.sv
module tb_usb_dev_responder;

  logic        clk;
  logic        rst_L;
  logic        rx_valid;
  logic [3:0]  rx_pid;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_endp;
  logic [63:0] rx_data;
  logic        rx_error;
  logic        tx_pktready;
  logic [3:0]  tx_pid;
  logic [63:0] tx_data;
  logic        tx_pkttype;
  logic        tx_gotpkt;
  logic        tx_sending;
  logic [3:0]  mem_ptr;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] P_OUT = 4'b0001;
  localparam logic [3:0] P_IN  = 4'b1001;
  localparam logic [3:0] P_D0  = 4'b0011;
  localparam logic [3:0] P_ACK = 4'b0010;
  localparam logic [3:0] P_NAK = 4'b1010;

  usb_dev_responder dut (
    .clk         (clk),
    .rst_L       (rst_L),
    .rx_valid    (rx_valid),
    .rx_pid      (rx_pid),
    .rx_addr     (rx_addr),
    .rx_endp     (rx_endp),
    .rx_data     (rx_data),
    .rx_error    (rx_error),
    .tx_pktready (tx_pktready),
    .tx_pid      (tx_pid),
    .tx_data     (tx_data),
    .tx_pkttype  (tx_pkttype),
    .tx_gotpkt   (tx_gotpkt),
    .tx_sending  (tx_sending),
    .mem_ptr     (mem_ptr),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle packet on the receive side; returns at the negedge after it was consumed.
  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr,
                          input logic [3:0] endp, input logic [63:0] dat,
                          input logic err);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_pid   = pid;
    rx_addr  = addr;
    rx_endp  = endp;
    rx_data  = dat;
    rx_error = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  // Encoder model: waits (bounded) for a request, reports what it saw, accepts it and plays out a short send.
  task automatic serve_tx(output bit got, output logic [3:0] pid, output logic typ,
                          output logic [63:0] dat, output bit stable);
    got = 1'b0;
    stable = 1'b0;
    pid = 4'd0;
    typ = 1'b0;
    dat = 64'd0;
    for (int i = 0; i < 20; i++) begin
      if (tx_pktready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      pid = tx_pid;
      typ = tx_pkttype;
      dat = tx_data;
      @(negedge clk);
      stable = tx_pktready && (tx_pid == pid) && (tx_pkttype == typ) && (tx_data == dat);
      tx_gotpkt = 1'b1;
      @(negedge clk);
      tx_gotpkt  = 1'b0;
      tx_sending = 1'b1;
      repeat (3) @(negedge clk);
      tx_sending = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic set_ptr(input logic [63:0] v);
    bit g, s;
    logic [3:0] p;
    logic t;
    logic [63:0] d;
    send_pkt(P_OUT, 7'd5, 4'd4, 64'd0, 1'b0);
    send_pkt(P_D0, 7'd0, 4'd0, v, 1'b0);
    serve_tx(g, p, t, d, s);
  endtask

  task automatic test_reset;
    rst_L = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_pktready !== 1'b0) begin errors++; $display("FAIL reset_pktready got=%b want=0", tx_pktready); end
    checks++; if (tx_pid !== 4'd0) begin errors++; $display("FAIL reset_pid got=%h want=0", tx_pid); end
    checks++; if (tx_data !== 64'd0) begin errors++; $display("FAIL reset_data got=%h want=0", tx_data); end
    checks++; if (tx_pkttype !== 1'b0) begin errors++; $display("FAIL reset_pkttype got=%b want=0", tx_pkttype); end
    checks++; if (mem_ptr !== 4'd0) begin errors++; $display("FAIL reset_ptr got=%0d want=0", mem_ptr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addr_write;
    bit g, s;
    logic [3:0] p;
    logic t;
    logic [63:0] d;
    send_pkt(P_OUT, 7'd5, 4'd4, 64'd0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL addr_busy got=%b want=1", busy); end
    send_pkt(P_D0, 7'd0, 4'd0, 64'h3, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL addr_got got=%b want=1", g); end
    checks++; if (p !== P_ACK) begin errors++; $display("FAIL addr_pid got=%b want=0010", p); end
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL addr_type got=%b want=0", t); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL addr_stable got=%b want=1", s); end
    checks++; if (mem_ptr !== 4'd3) begin errors++; $display("FAIL addr_ptr got=%0d want=3", mem_ptr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL addr_idle got=%b want=0", busy); end
  endtask

  task automatic test_write_read;
    bit g, s;
    logic [3:0] p;
    logic t;
    logic [63:0] d;
    send_pkt(P_OUT, 7'd5, 4'd8, 64'd0, 1'b0);
    send_pkt(P_D0, 7'd0, 4'd0, 64'hDEADBEEF_CAFEF00D, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (p !== P_ACK) begin errors++; $display("FAIL wr_pid got=%b want=0010", p); end
    checks++; if (mem_ptr !== 4'd4) begin errors++; $display("FAIL wr_ptr got=%0d want=4", mem_ptr); end
    set_ptr(64'hFFFF_FFFF_FFFF_FFF3);
    checks++; if (mem_ptr !== 4'd3) begin errors++; $display("FAIL wr_ptr_upper got=%0d want=3", mem_ptr); end
    send_pkt(P_IN, 7'd5, 4'd8, 64'd0, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL rd_got got=%b want=1", g); end
    checks++; if (p !== P_D0) begin errors++; $display("FAIL rd_pid got=%b want=0011", p); end
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL rd_type got=%b want=1", t); end
    checks++; if (d !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL rd_data got=%h want=deadbeefcafef00d", d); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL rd_stable got=%b want=1", s); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_waiths got=%b want=1", busy); end
    send_pkt(P_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
    checks++; if (mem_ptr !== 4'd4) begin errors++; $display("FAIL rd_ack_ptr got=%0d want=4", mem_ptr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_ack_idle got=%b want=0", busy); end
  endtask

  task automatic test_nak_retry;
    bit g, s;
    logic [3:0] p;
    logic t;
    logic [63:0] d;
    set_ptr(64'h3);
    send_pkt(P_IN, 7'd5, 4'd8, 64'd0, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (d !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL nak_first got=%h want=deadbeefcafef00d", d); end
    send_pkt(P_NAK, 7'd0, 4'd0, 64'd0, 1'b0);
    checks++; if (mem_ptr !== 4'd3) begin errors++; $display("FAIL nak_ptr got=%0d want=3", mem_ptr); end
    send_pkt(P_IN, 7'd5, 4'd8, 64'd0, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (d !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL nak_retry got=%h want=deadbeefcafef00d", d); end
    send_pkt(P_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
    checks++; if (mem_ptr !== 4'd3) begin errors++; $display("FAIL nak_errack_ptr got=%0d want=3", mem_ptr); end
    send_pkt(P_IN, 7'd5, 4'd8, 64'd0, 1'b0);
    serve_tx(g, p, t, d, s);
    send_pkt(P_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
    checks++; if (mem_ptr !== 4'd4) begin errors++; $display("FAIL nak_final_ptr got=%0d want=4", mem_ptr); end
  endtask

  task automatic test_errors;
    bit g, s, saw;
    logic [3:0] p;
    logic t;
    logic [63:0] d;
    set_ptr(64'h3);
    send_pkt(P_OUT, 7'd5, 4'd8, 64'd0, 1'b0);
    send_pkt(P_D0, 7'd0, 4'd0, 64'h1111_2222_3333_4444, 1'b1);
    serve_tx(g, p, t, d, s);
    checks++; if (p !== P_NAK) begin errors++; $display("FAIL err_pid got=%b want=1010", p); end
    checks++; if (mem_ptr !== 4'd3) begin errors++; $display("FAIL err_ptr got=%0d want=3", mem_ptr); end
    send_pkt(P_IN, 7'd5, 4'd8, 64'd0, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (d !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL err_mem got=%h want=deadbeefcafef00d", d); end
    send_pkt(P_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
    // Foreign address: nothing may happen.
    send_pkt(P_OUT, 7'd6, 4'd8, 64'd0, 1'b0);
    saw = busy || tx_pktready;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || tx_pktready) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL err_foreign got=%b want=0", saw); end
    // IN to the address endpoint is refused.
    send_pkt(P_IN, 7'd5, 4'd4, 64'd0, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (p !== P_NAK) begin errors++; $display("FAIL err_in_addr got=%b want=1010", p); end
    // Unexpected token while waiting for data abandons the transaction.
    send_pkt(P_OUT, 7'd5, 4'd8, 64'd0, 1'b0);
    send_pkt(P_IN, 7'd5, 4'd8, 64'd0, 1'b0);
    checks++; if ((busy | tx_pktready) !== 1'b0) begin errors++; $display("FAIL err_abandon busy=%b rdy=%b want=0", busy, tx_pktready); end
  endtask

  task automatic test_timeout_wrap;
    bit g, s, saw;
    logic [3:0] p;
    logic t;
    logic [63:0] d;
    send_pkt(P_OUT, 7'd5, 4'd8, 64'd0, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (tx_pktready) saw = 1'b1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_early got=%b want=1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got=%b want=0", busy); end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL to_tx got=%b want=0", saw); end
    set_ptr(64'hF);
    send_pkt(P_OUT, 7'd5, 4'd8, 64'd0, 1'b0);
    send_pkt(P_D0, 7'd0, 4'd0, 64'h0F0F_0F0F_A5A5_5A5A, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (mem_ptr !== 4'd0) begin errors++; $display("FAIL wrap_wr_ptr got=%0d want=0", mem_ptr); end
    set_ptr(64'hF);
    send_pkt(P_IN, 7'd5, 4'd8, 64'd0, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (d !== 64'h0F0F_0F0F_A5A5_5A5A) begin errors++; $display("FAIL wrap_rd got=%h want=0f0f0f0fa5a55a5a", d); end
    send_pkt(P_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
    checks++; if (mem_ptr !== 4'd0) begin errors++; $display("FAIL wrap_rd_ptr got=%0d want=0", mem_ptr); end
  endtask

  task automatic test_reset_midflight;
    bit g, s;
    logic [3:0] p;
    logic t;
    logic [63:0] d;
    send_pkt(P_OUT, 7'd5, 4'd8, 64'd0, 1'b0);
    send_pkt(P_D0, 7'd0, 4'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
    serve_tx(g, p, t, d, s);
    send_pkt(P_IN, 7'd5, 4'd8, 64'd0, 1'b0);
    checks++; if (tx_pktready !== 1'b1) begin errors++; $display("FAIL mid_req got=%b want=1", tx_pktready); end
    #2 rst_L = 1'b0;
    #1;
    checks++; if ({tx_pktready, tx_pid, tx_pkttype} !== 6'd0) begin errors++; $display("FAIL mid_outs rdy=%b pid=%b type=%b want=0", tx_pktready, tx_pid, tx_pkttype); end
    checks++; if (tx_data !== 64'd0) begin errors++; $display("FAIL mid_data got=%h want=0", tx_data); end
    checks++; if ((busy !== 1'b0) || (mem_ptr !== 4'd0)) begin errors++; $display("FAIL mid_state busy=%b ptr=%0d want=0", busy, mem_ptr); end
    @(negedge clk);
    rst_L = 1'b1;
    send_pkt(P_IN, 7'd5, 4'd8, 64'd0, 1'b0);
    serve_tx(g, p, t, d, s);
    checks++; if (d !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL mid_after got=%h want=0123456789abcdef", d); end
    send_pkt(P_ACK, 7'd0, 4'd0, 64'd0, 1'b0);
    checks++; if (mem_ptr !== 4'd1) begin errors++; $display("FAIL mid_after_ptr got=%0d want=1", mem_ptr); end
  endtask

  initial begin
    rst_L      = 1'b0;
    rx_valid   = 1'b0;
    rx_pid     = 4'd0;
    rx_addr    = 7'd0;
    rx_endp    = 4'd0;
    rx_data    = 64'd0;
    rx_error   = 1'b0;
    tx_gotpkt  = 1'b0;
    tx_sending = 1'b0;
    test_reset();
    test_addr_write();
    test_write_read();
    test_nak_retry();
    test_errors();
    test_timeout_wrap();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_dev_responder.md
Name: usb_dev_responder

Overview:
Device-side USB transaction responder, the far end of the host pipeOut/pipeIn pair. It consumes decoded packets from a device receive pipeline, answers OUT/IN tokens addressed to it, and drives a device transmit pipeline with handshake or DATA0 packets. It owns a small 64-bit word memory reached through an address endpoint and a data endpoint, so it serves as the bus-functional peer for host-side verification.

Parameters:
DEV_ADDR, 7'd5, USB device address this responder answers to
MEM_WORDS, 16, number of 64-bit memory words (power of 2)
TIMEOUT, 255, cycles to wait for the next expected packet before abandoning a transaction
ADDR_ENDP, 4'd4, endpoint whose OUT data sets the memory pointer
DATA_ENDP, 4'd8, endpoint whose OUT data writes and IN data reads memory

Ports:
clk  input  1  clock
rst_L  input  1  asynchronous active-low reset
rx_valid  input  1  one-cycle pulse: decoded packet present on rx_* fields
rx_pid  input  4  PID of received packet
rx_addr  input  7  token address field (valid for tokens)
rx_endp  input  4  token endpoint field (valid for tokens)
rx_data  input  64  payload (valid for DATA0)
rx_error  input  1  with rx_valid: CRC/stuffing/format error on this packet
tx_pktready  output  1  request to transmit the packet on tx_*
tx_pid  output  4  PID to transmit
tx_data  output  64  payload for DATA0
tx_pkttype  output  1  0 = handshake, 1 = data packet
tx_gotpkt  input  1  encoder accepted current request (one-cycle pulse)
tx_sending  input  1  encoder/line driver busy
mem_ptr  output  log2(MEM_WORDS)  current memory pointer (debug/visibility)
busy  output  1  high in any state other than IDLE

Behaviour:
- Single clock clk; reset is asynchronous and active-low on rst_L. Reset: state IDLE, tx_pktready=0, tx_pid=0, tx_data=0, tx_pkttype=0, mem_ptr=0, busy=0, timer=0; memory contents not reset.
- PIDs: OUT=4'b0001, IN=4'b1001, DATA0=4'b0011, ACK=4'b0010, NAK=4'b1010. Any other PID is ignored.
- Token match: rx_valid & ~rx_error & rx_addr==DEV_ADDR & rx_endp in {ADDR_ENDP, DATA_ENDP}. Non-matching tokens are ignored in IDLE (no response).
- States: IDLE, WAIT_DATA, SEND_HS, SEND_DATA, WAIT_HS, TX_DRAIN.
- IDLE: matching OUT -> latch endp, timer=0, WAIT_DATA. Matching IN to DATA_ENDP -> SEND_DATA. IN to ADDR_ENDP -> SEND_HS with NAK.
- WAIT_DATA: timer increments each cycle. rx_valid DATA0 with ~rx_error -> perform write, SEND_HS with ACK. Write: ADDR_ENDP sets mem_ptr=rx_data[log2(MEM_WORDS)-1:0], upper bits ignored; DATA_ENDP writes mem[mem_ptr]=rx_data, then mem_ptr increments modulo MEM_WORDS (wraps MEM_WORDS-1 -> 0). DATA0 with rx_error -> SEND_HS with NAK, no write. Any other rx_valid -> IDLE, no response. timer==TIMEOUT -> IDLE, no response.
- SEND_HS: tx_pktready=1, tx_pkttype=0, tx_pid=ACK/NAK, held stable until tx_gotpkt; on tx_gotpkt drop tx_pktready the next cycle, go TX_DRAIN with return target IDLE.
- SEND_DATA: tx_pktready=1, tx_pkttype=1, tx_pid=DATA0, tx_data=mem[mem_ptr] captured on entry and held stable; on tx_gotpkt -> TX_DRAIN with return target WAIT_HS.
- TX_DRAIN: wait one cycle after gotpkt, then remain until tx_sending==0; go to return target, timer=0.
- WAIT_HS: ACK (no error) -> mem_ptr increments modulo MEM_WORDS, IDLE. NAK, errored packet, or timer==TIMEOUT -> IDLE, mem_ptr unchanged (host retry re-reads same word). Other packets -> IDLE, pointer unchanged.
- rx_valid in SEND_*/TX_DRAIN is ignored (half-duplex; device never listens while transmitting).
- tx_pktready never asserts while tx_sending=1 outside the cycle of its own request.
- Reset asserted mid-transaction: immediate return to reset values; an in-flight tx request is withdrawn.
- Timer is $clog2(TIMEOUT+1) bits, saturates never (exit occurs at equality).

Test Plan:
- OUT addr=5 endp=4, DATA0 rx_data=64'h3 -> ACK sent (tx_pid=4'b0010, tx_pkttype=0), mem_ptr=3.
- OUT endp=8 DATA0 64'hDEADBEEF_CAFEF00D, then IN endp=8 after pointer reset to 3 -> DATA0 with tx_data=64'hDEADBEEF_CAFEF00D; host ACK -> mem_ptr=4.
- IN endp=8, host answers NAK, repeat IN -> same tx_data both times, mem_ptr unchanged until ACK.
- OUT endp=8 then DATA0 with rx_error=1 -> NAK, memory word unchanged; OUT with rx_addr=6 -> no tx_pktready, busy stays 0.
- OUT endp=8 with no DATA0 for TIMEOUT cycles -> return to IDLE at cycle TIMEOUT, no transmit; pointer at 15 after write wraps to 0.
- Assert rst_L=0 while tx_pktready=1 in SEND_DATA -> all outputs zero immediately, busy=0, next IN handled normally.
